// File: rtl/zap_copro_dispatch.sv
// Coprocessor dispatch controller: routes a coprocessor instruction from the
// predecode stage to one of two coprocessor slots. It waits for ack and
// completion, and returns a done/undef response that is held until
// predecode drops its request.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for i_copro_dav; latches the word and decodes CP number
// DISPATCH | request asserted to selected slot, counting cycles until ack
// EXEC     | slot accepted, waiting for its done pulse (abort may be noted)
// RESP     | o_copro_done held (o_undef qualified) until dav is sampled low
module zap_copro_dispatch #(
    parameter logic [3:0] CP0_NUM     = 4'd15,
    parameter logic [3:0] CP1_NUM     = 4'd14,
    parameter int         ACK_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_copro_dav,
    input  logic [31:0] i_copro_word,
    output logic        o_copro_done,
    output logic        o_undef,
    output logic        o_cp0_req,
    output logic        o_cp1_req,
    output logic [31:0] o_cp_word,
    input  logic        i_cp0_ack,
    input  logic        i_cp1_ack,
    input  logic        i_cp0_done,
    input  logic        i_cp1_done,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_EXEC     = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic        r_sel, w_sel_nxt;       // 0 = slot 0, 1 = slot 1
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_undef, w_undef_nxt;
    logic        r_abort, w_abort_nxt;
    logic [31:0] r_cp_word, w_cp_word_nxt;

    logic        w_ack;
    logic        w_done;

    // Only the selected slot's handshake is ever looked at.
    assign w_ack  = r_sel ? i_cp1_ack  : i_cp0_ack;
    assign w_done = r_sel ? i_cp1_done : i_cp0_done;

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_sel     <= 1'b0;
            r_cnt     <= 8'd0;
            r_undef   <= 1'b0;
            r_abort   <= 1'b0;
            r_cp_word <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_cnt     <= w_cnt_nxt;
            r_undef   <= w_undef_nxt;
            r_abort   <= w_abort_nxt;
            r_cp_word <= w_cp_word_nxt;
        end
    end

    // Next-state and flag update logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_cnt_nxt     = r_cnt;
        w_undef_nxt   = r_undef;
        w_abort_nxt   = r_abort;
        w_cp_word_nxt = r_cp_word;
        case (r_state)
            S_IDLE: begin
                if (i_copro_dav) begin
                    w_cp_word_nxt = i_copro_word;
                    w_cnt_nxt     = 8'd0;
                    if (i_copro_word[11:8] == CP0_NUM) begin
                        w_sel_nxt   = 1'b0;
                        w_undef_nxt = 1'b0;
                        w_state_nxt = S_DISPATCH;
                    end else if (i_copro_word[11:8] == CP1_NUM) begin
                        w_sel_nxt   = 1'b1;
                        w_undef_nxt = 1'b0;
                        w_state_nxt = S_DISPATCH;
                    end else begin
                        w_undef_nxt = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_DISPATCH: begin
                // A dropped request wins over any handshake in the same cycle.
                if (!i_copro_dav) begin
                    w_state_nxt = S_IDLE;
                end else if (w_ack) begin
                    w_undef_nxt = 1'b0;
                    w_state_nxt = w_done ? S_RESP : S_EXEC;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_undef_nxt = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_EXEC: begin
                // The slot must still finish before we can go idle, even if aborted.
                if (w_done) begin
                    w_undef_nxt = 1'b0;
                    w_state_nxt = (r_abort || !i_copro_dav) ? S_IDLE : S_RESP;
                end else if (!i_copro_dav) begin
                    w_abort_nxt = 1'b1;
                end
            end
            S_RESP: begin
                if (!i_copro_dav) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt == S_IDLE) begin
            w_abort_nxt = 1'b0;
        end
    end

    assign o_cp0_req    = (r_state == S_DISPATCH) && !r_sel;
    assign o_cp1_req    = (r_state == S_DISPATCH) &&  r_sel;
    assign o_copro_done = (r_state == S_RESP);
    assign o_undef      = (r_state == S_RESP) && r_undef;
    assign o_busy       = (r_state != S_IDLE);
    assign o_cp_word    = r_cp_word;

endmodule

// File: tb/tb_zap_copro_dispatch.sv
// Bench for zap_copro_dispatch: directed scenarios plus randomized
// transactions. Expected outputs come from a transaction-level timeline
// (which cycle the req ends, when done starts, when the block goes idle).
module tb_zap_copro_dispatch;

    localparam int T = 4;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_copro_dav = 1'b0;
    logic [31:0] i_copro_word = 32'd0;
    logic        o_copro_done, o_undef, o_cp0_req, o_cp1_req, o_busy;
    logic [31:0] o_cp_word;
    logic        i_cp0_ack = 1'b0, i_cp1_ack = 1'b0;
    logic        i_cp0_done = 1'b0, i_cp1_done = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    zap_copro_dispatch #(.CP0_NUM(4'd15), .CP1_NUM(4'd14), .ACK_TIMEOUT(T)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_copro_dav(i_copro_dav), .i_copro_word(i_copro_word),
        .o_copro_done(o_copro_done), .o_undef(o_undef),
        .o_cp0_req(o_cp0_req), .o_cp1_req(o_cp1_req), .o_cp_word(o_cp_word),
        .i_cp0_ack(i_cp0_ack), .i_cp1_ack(i_cp1_ack),
        .i_cp0_done(i_cp0_done), .i_cp1_done(i_cp1_done),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Packed view: {cp0_req, cp1_req, copro_done, undef, busy}
    function automatic logic [4:0] outs();
        return {o_cp0_req, o_cp1_req, o_copro_done, o_undef, o_busy};
    endfunction

    task automatic check5(input string tag, input int k, input logic [4:0] exp);
        n_checks++;
        assert (outs() === exp) n_pass++;
        else $error("FAIL %s k=%0d observed=%b expected=%b (req0 req1 done undef busy)",
                    tag, k, outs(), exp);
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // scen: 0 ack then done, 1 ack timeout, 2 abort in DISPATCH, 3 abort in EXEC.
    // ka/kd = edge index at which ack/done is sampled (edge 0 = accept edge),
    // kx = edge at which dav is first sampled low for aborts, s = stall cycles in RESP.
    task automatic run_txn(input string tag, input logic [31:0] word, input int scen,
                           input int ka_in, input int kd_in, input int kx, input int s);
        int  kind, ka, kd, reqend, r, endi, davend;
        bit  und, has_done;
        logic [4:0] exp;
        ka = ka_in; kd = kd_in;
        kind = (word[11:8] == 4'd15) ? 0 : (word[11:8] == 4'd14) ? 1 : 2;
        und = 1'b0; has_done = 1'b1; r = 0; reqend = 0;
        if (kind == 2) begin
            und = 1'b1; r = 0; endi = 1 + s; ka = 1000; kd = 1000;
        end else begin
            case (scen)
                0: begin reqend = ka; r = kd; endi = kd + 1 + s; end
                1: begin ka = 1000; kd = 1000; reqend = T; r = T; und = 1'b1; endi = T + 1 + s; end
                2: begin ka = 1000; kd = 1000; reqend = kx; has_done = 1'b0; endi = kx; end
                default: begin reqend = ka; has_done = 1'b0; endi = kd; end
            endcase
        end
        davend = (kind != 2 && scen >= 2) ? kx : endi;
        for (int k = 0; k <= endi + 1; k++) begin
            i_copro_dav  = (k < davend);
            i_copro_word = (k == 0) ? word : $urandom;
            i_cp0_ack  = (kind == 0) ? (k == ka) : 1'($urandom);
            i_cp1_ack  = (kind == 1) ? (k == ka) : 1'($urandom);
            i_cp0_done = (kind == 0) ? (k == kd) : 1'($urandom);
            i_cp1_done = (kind == 1) ? (k == kd) : 1'($urandom);
            @(posedge i_clk); #2;
            exp[4] = (kind == 0) && (k < reqend);
            exp[3] = (kind == 1) && (k < reqend);
            exp[2] = has_done && (k >= r) && (k < endi);
            exp[1] = exp[2] && und;
            exp[0] = (k < endi);
            check5(tag, k, exp);
            if (k == 0) check32({tag, "_word"}, o_cp_word, word);
        end
        i_cp0_ack = 1'b0; i_cp1_ack = 1'b0; i_cp0_done = 1'b0; i_cp1_done = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        int scen, ka, kd, kx, s, sel;
        #3;
        check5("reset_outs", 0, 5'b00000);
        check32("reset_word", o_cp_word, 32'd0);
        @(negedge i_clk); i_reset_n = 1'b1;
        @(posedge i_clk); #2;

        run_txn("cp15_mrc",   32'hEE110F10, 0, 2, 5, 0, 2);
        run_txn("undef_cp7",  32'h00000700, 0, 0, 0, 0, 0);
        run_txn("timeout",    32'hEE100E10, 1, 0, 0, 0, 1);
        run_txn("abort_exec", 32'hEE110F10, 3, 1, 7, 2, 0);
        run_txn("stall3",     32'hEE110F10, 0, 1, 3, 0, 3);
        run_txn("next_req",   32'hEE100E10, 0, 3, 4, 0, 0);
        run_txn("ack_done",   32'hEE110F10, 0, 3, 3, 0, 1);
        run_txn("abort_disp", 32'hEE100E10, 2, 0, 0, 2, 0);
        run_txn("abort_at_to",32'hEE110F10, 2, 0, 0, T, 0);
        run_txn("ack_at_to",  32'hEE100E10, 0, T, T + 2, 0, 0);

        for (int n = 0; n < 60; n++) begin
            w = $urandom;
            sel = $urandom_range(0, 3);
            w[11:8] = (sel == 0) ? 4'd15 : (sel == 1) ? 4'd14 : 4'($urandom_range(0, 13));
            scen = $urandom_range(0, 3);
            ka = $urandom_range(1, T);
            kd = 0; kx = 0;
            case (scen)
                0: kd = ka + $urandom_range(0, 4);
                2: kx = $urandom_range(1, T);
                3: begin kd = ka + $urandom_range(2, 6); kx = $urandom_range(ka + 1, kd - 1); end
                default: ;
            endcase
            s = $urandom_range(0, 3);
            run_txn("random", w, scen, ka, kd, kx, s);
            repeat ($urandom_range(0, 2)) begin
                i_copro_dav = 1'b0;
                @(posedge i_clk); #2;
                check5("gap_idle", 0, 5'b00000);
            end
        end

        // Asynchronous reset in EXEC, then a stale done must be ignored.
        i_copro_word = 32'hEE110F10; i_copro_dav = 1'b1; i_cp0_ack = 1'b0;
        @(posedge i_clk); #2;
        i_cp0_ack = 1'b1;
        @(posedge i_clk); #2;
        i_cp0_ack = 1'b0;
        check5("exec_busy", 0, 5'b00001);
        #1 i_reset_n = 1'b0;
        #1 check5("async_reset", 0, 5'b00000);
        check32("async_reset_word", o_cp_word, 32'd0);
        @(negedge i_clk); i_reset_n = 1'b1; i_copro_dav = 1'b0; i_cp0_done = 1'b1;
        @(posedge i_clk); #2;
        i_cp0_done = 1'b0;
        check5("stale_done", 0, 5'b00000);
        @(posedge i_clk); #2;
        check5("stale_done2", 1, 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/zap_copro_dispatch.md
ZAP_COPRO_DISPATCH -- requirements
Module: zap_copro_dispatch

Interface
REQ-001 Parameter CP0_NUM, default 15, coprocessor number (instruction bits [11:8]) served by slot 0.
REQ-002 Parameter CP1_NUM, default 14, coprocessor number served by slot 1; SHALL differ from CP0_NUM.
REQ-003 Parameter ACK_TIMEOUT, default 255, max cycles in DISPATCH before undefined-instruction response; range 1..255.
REQ-004 i_clk  in  1  clock, all state on rising edge.
REQ-005 i_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 i_copro_dav  in  1  predecode requests coprocessor operation.
REQ-007 i_copro_word  in  32  full coprocessor instruction.
REQ-008 o_copro_done  out  1  operation finished; returned to predecode.
REQ-009 o_undef  out  1  qualifies o_copro_done: no coprocessor accepted the instruction.
REQ-010 o_cp0_req / o_cp1_req  out  1 each  per-slot request.
REQ-011 o_cp_word  out  32  registered instruction shared by both slots.
REQ-012 i_cp0_ack / i_cp1_ack  in  1 each  slot accepted request.
REQ-013 i_cp0_done / i_cp1_done  in  1 each  slot finished execution (single-cycle pulse).
REQ-014 o_busy  out  1  high in any state other than IDLE.

Function
REQ-015 States: IDLE, DISPATCH, EXEC, RESP; binary-encoded, registered.
REQ-016 IDLE: on i_copro_dav=1, latch i_copro_word into o_cp_word and decode bits [11:8]; match CP0_NUM -> selected slot 0, match CP1_NUM -> selected slot 1, then DISPATCH; no match -> RESP with undef flag set, no request issued.
REQ-017 DISPATCH: assert o_cpN_req only for the selected slot, registered, first high the cycle after the IDLE accept; the other slot's req stays 0.
REQ-018 DISPATCH: i_cpN_ack of the selected slot sampled 1 -> req drops next cycle, go EXEC; ack from the non-selected slot is ignored.
REQ-019 DISPATCH: 8-bit wait counter clears on entry and increments each cycle without ack; counter == ACK_TIMEOUT-1 with no ack -> drop req, set undef flag, go RESP.
REQ-020 EXEC: wait for selected slot's i_cpN_done; on done go RESP with undef flag clear.
REQ-021 RESP: o_copro_done=1 and o_undef=undef flag, held (not pulsed) until i_copro_dav is sampled 0, then IDLE; covers predecode being stalled and missing a single-cycle done.
REQ-022 Abort: i_copro_dav=0 in DISPATCH -> drop req next cycle, IDLE, no done.
REQ-023 Abort: i_copro_dav=0 in EXEC -> set abort flag, stay in EXEC until selected done, then IDLE directly without entering RESP; abort flag clears on IDLE entry.
REQ-024 Ack and done from the selected slot in the same DISPATCH cycle -> treated as ack followed by done: go RESP directly.
REQ-025 A new request is never accepted in the cycle of the RESP->IDLE transition; IDLE samples i_copro_dav from the next cycle.
REQ-026 o_undef is 0 whenever o_copro_done is 0.
REQ-027 All outputs are driven directly from flops or from state decode only; no combinational path from any input to any output.

Reset
REQ-028 i_reset_n=0 asynchronously forces: state IDLE, o_cp0_req=0, o_cp1_req=0, o_copro_done=0, o_undef=0, o_busy=0, o_cp_word=32'd0, wait counter 0, undef and abort flags 0.
REQ-029 Reset asserted mid-operation abandons the operation; slot done pulses arriving after reset release in IDLE are ignored.

Verification
REQ-030 Word 0xEE110F10 (CP15 MRC), dav held; slot0 ack at cycle 3 and done at cycle 6 -> o_cp0_req high cycles 2-3, o_copro_done=1 o_undef=0 from cycle 7 until dav drops, o_cp1_req never high.
REQ-031 Word with bits [11:8]=4'd7 -> RESP next cycle, o_copro_done=1 o_undef=1, no req asserted.
REQ-032 CP14 word, slot1 never acks, ACK_TIMEOUT=4 -> o_cp1_req high exactly 4 cycles, then done with o_undef=1.
REQ-033 Slot0 acks, dav drops during EXEC, done arrives 5 cycles later -> no o_copro_done, o_busy falls cycle after done.
REQ-034 Predecode stalls dav high 3 cycles after done -> o_copro_done stays high 3+ cycles, single completion; then next request accepted normally.
REQ-035 Assert i_reset_n=0 in EXEC between clock edges -> all outputs reach reset values immediately, before next clock edge.
